text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_text_console_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Character-cell console writer: turns a byte stream into screen-RAM writes,
// tracking a cursor and a scrolling top row, with line and full-screen blanking.
module text_console_writer #(
   parameter int COLS           = 160,
   parameter int ROWS           = 50,
   parameter int ADDR_W         = 13,
   parameter int ATTR_W         = 4,
   parameter int BLANK_ATTR     = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7:0]                in_char,
   input  logic [ATTR_W-1:0]         in_attr,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [ATTR_W+7:0]         wr_data,
   output logic [$clog2(COLS)-1:0]   cursor_col,
   output logic [$clog2(ROWS)-1:0]   cursor_row,
   output logic [$clog2(ROWS)-1:0]   scroll_row,
   output logic                      busy
);

   localparam int COL_W  = $clog2(COLS);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int SUM_W  = ROW_W + 1;
   localparam int CNT_W  = ADDR_W + 1;

   localparam logic [COL_W-1:0]     LAST_COL   = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]     LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [SUM_W-1:0]     ROWS_SUM   = SUM_W'(ROWS);
   localparam logic [CNT_W-1:0]     LINE_CNT   = CNT_W'(COLS);
   localparam logic [CNT_W-1:0]     ALL_CNT    = CNT_W'(ROWS * COLS);
   localparam logic [ATTR_W+7:0]    BLANK_CELL = {ATTR_W'(BLANK_ATTR), 8'h20};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLEAR_LINE = 2'd1,
      CLEAR_ALL  = 2'd2
   } state_t;

   // Holding the clear state during reset lets the first blanking write
   // leave on the very first edge that sees reset low.
   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR_ALL : IDLE;

   state_t                r_state;
   state_t                w_state_nx;

   logic [COL_W-1:0]      r_col,    w_col_nx;
   logic [ROW_W-1:0]      r_row,    w_row_nx;
   logic [ROW_W-1:0]      r_scroll, w_scroll_nx;
   logic [CNT_W-1:0]      r_cnt,    w_cnt_nx;
   logic [ADDR_W-1:0]     r_base,   w_base_nx;
   logic                  r_wr_en,  w_wr_en_nx;
   logic [ADDR_W-1:0]     r_wr_addr, w_wr_addr_nx;
   logic [ATTR_W+7:0]     r_wr_data, w_wr_data_nx;
   logic                  r_in_ready;
   logic                  r_busy;
   logic                  w_newline;
   logic                  w_accept;
   logic [ADDR_W-1:0]     w_cur_addr;

   // Physical cell address of a logical (row, col) under the current scroll.
   function automatic logic [ADDR_W-1:0] cell_addr(
      input logic [ROW_W-1:0] row,
      input logic [ROW_W-1:0] scroll,
      input logic [COL_W-1:0] col
   );
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] phys;
      sum = {1'b0, row} + {1'b0, scroll};
      if (sum >= ROWS_SUM) begin
         phys = sum - ROWS_SUM;
      end else begin
         phys = sum;
      end
      return (ADDR_W'(phys) * ADDR_W'(COLS)) + ADDR_W'(col);
   endfunction

   assign w_accept   = in_valid && r_in_ready;
   assign w_cur_addr = cell_addr(r_row, r_scroll, r_col);

   // Next-state, cursor and write-port decisions.
   always_comb begin
      w_state_nx   = r_state;
      w_col_nx     = r_col;
      w_row_nx     = r_row;
      w_scroll_nx  = r_scroll;
      w_cnt_nx     = r_cnt;
      w_base_nx    = r_base;
      w_wr_en_nx   = 1'b0;
      w_wr_addr_nx = r_wr_addr;
      w_wr_data_nx = r_wr_data;
      w_newline    = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if ((in_char >= 8'h20) && (in_char <= 8'h7E)) begin
                  w_wr_en_nx   = 1'b1;
                  w_wr_addr_nx = w_cur_addr;
                  w_wr_data_nx = {in_attr, in_char};
                  if (r_col == LAST_COL) begin
                     w_col_nx  = '0;
                     w_newline = 1'b1;
                  end else begin
                     w_col_nx  = r_col + 1'b1;
                  end
               end else begin
                  case (in_char)
                     8'h0A: begin
                        w_col_nx  = '0;
                        w_newline = 1'b1;
                     end
                     8'h0D: begin
                        w_col_nx = '0;
                     end
                     8'h08: begin
                        if (r_col != '0) begin
                           w_col_nx     = r_col - 1'b1;
                           w_wr_en_nx   = 1'b1;
                           w_wr_addr_nx = cell_addr(r_row, r_scroll, r_col - 1'b1);
                           w_wr_data_nx = BLANK_CELL;
                        end else begin
                           w_col_nx = r_col;
                        end
                     end
                     8'h0C: begin
                        w_state_nx  = CLEAR_ALL;
                        w_col_nx    = '0;
                        w_row_nx    = '0;
                        w_scroll_nx = '0;
                        w_cnt_nx    = '0;
                        w_base_nx   = '0;
                     end
                     default: begin
                        w_col_nx = r_col;
                     end
                  endcase
               end
            end else begin
               w_state_nx = IDLE;
            end

            // The row leaving the top becomes the new bottom row and is blanked.
            if (w_newline) begin
               if (r_row == LAST_ROW) begin
                  w_scroll_nx = (r_scroll == LAST_ROW) ? '0 : r_scroll + 1'b1;
                  w_state_nx  = CLEAR_LINE;
                  w_cnt_nx    = '0;
                  w_base_nx   = cell_addr('0, r_scroll, '0);
               end else begin
                  w_row_nx    = r_row + 1'b1;
               end
            end else begin
               w_newline = 1'b0;
            end
         end

         CLEAR_LINE, CLEAR_ALL: begin
            if (r_cnt == ((r_state == CLEAR_LINE) ? LINE_CNT : ALL_CNT)) begin
               w_state_nx = IDLE;
            end else begin
               w_wr_en_nx   = 1'b1;
               w_wr_addr_nx = r_base + ADDR_W'(r_cnt);
               w_wr_data_nx = BLANK_CELL;
               w_cnt_nx     = r_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Cursor, clear counter and registered output port.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col      <= '0;
         r_row      <= '0;
         r_scroll   <= '0;
         r_cnt      <= '0;
         r_base     <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_col      <= w_col_nx;
         r_row      <= w_row_nx;
         r_scroll   <= w_scroll_nx;
         r_cnt      <= w_cnt_nx;
         r_base     <= w_base_nx;
         r_wr_en    <= w_wr_en_nx;
         r_wr_addr  <= w_wr_addr_nx;
         r_wr_data  <= w_wr_data_nx;
         r_in_ready <= (w_state_nx == IDLE);
         r_busy     <= (w_state_nx != IDLE);
      end
   end

   assign in_ready   = r_in_ready;
   assign busy       = r_busy;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign cursor_col = r_col;
   assign cursor_row = r_row;
   assign scroll_row = r_scroll;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer on a 4x3 screen: one instance
// without and one with clear-on-reset.
module tb_text_console_writer;

   localparam int COLS   = 4;
   localparam int ROWS   = 3;
   localparam int ADDR_W = 4;
   localparam int ATTR_W = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [ATTR_W+7:0]   data;
   } wr_t;

   logic                clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst0, in_valid, in_ready, wr_en, busy;
   logic [7:0]          in_char;
   logic [ATTR_W-1:0]   in_attr;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ATTR_W+7:0]   wr_data;
   logic [1:0]          cursor_col, cursor_row, scroll_row;

   logic                rst1, in_valid1, in_ready1, wr_en1, busy1;
   logic [7:0]          in_char1;
   logic [ATTR_W-1:0]   in_attr1;
   logic [ADDR_W-1:0]   wr_addr1;
   logic [ATTR_W+7:0]   wr_data1;
   logic [1:0]          cursor_col1, cursor_row1, scroll_row1;

   wr_t                 exp_q[$];
   int                  n_checks = 0;
   int                  n_fails  = 0;

   text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ATTR_W(ATTR_W),
                         .BLANK_ATTR(0), .CLEAR_ON_RESET(0)) dut (
      .clk(clk), .reset(rst0), .in_valid(in_valid), .in_ready(in_ready),
      .in_char(in_char), .in_attr(in_attr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .scroll_row(scroll_row), .busy(busy));

   text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ATTR_W(ATTR_W),
                         .BLANK_ATTR(0), .CLEAR_ON_RESET(1)) dut_cor (
      .clk(clk), .reset(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_char(in_char1), .in_attr(in_attr1), .wr_en(wr_en1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .cursor_col(cursor_col1), .cursor_row(cursor_row1),
      .scroll_row(scroll_row1), .busy(busy1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int addr, input logic [ATTR_W+7:0] data);
      wr_t e;
      e.addr = ADDR_W'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Pops one expected write for every write the DUT presents.
   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected no write",
                        wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", wr_addr, e.addr);
               check("write_data", wr_data, e.data);
            end
         end
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", in_ready, 1'b1);
   endtask

   task automatic send(input logic [7:0] c, input logic [ATTR_W-1:0] a);
      wait_ready();
      in_valid = 1'b1;
      in_char  = c;
      in_attr  = a;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_char  = 8'h00;
      in_attr  = '0;
   endtask

   task automatic count_low(output int n);
      n = 0;
      @(negedge clk);
      check("clear_busy", busy, 1'b1);
      while (in_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic reset0();
      @(posedge clk);
      #1 rst0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_ready_busy", {in_ready, busy}, 2'b00);
      check("rst_cursor", {cursor_col, cursor_row, scroll_row}, 6'd0);
      check("rst_wr_port", {wr_addr, wr_data}, 16'd0);
      @(posedge clk);
      #1 rst0 = 1'b0;
   endtask

   task automatic lf_scroll(input int base, input int exp_scroll);
      int n;
      for (int i = 0; i < COLS; i++) push(base + i, 12'h020);
      send(8'h0A, 4'h0);
      count_low(n);
      check("lf_ready_low_cycles", n, 5);
      check("lf_scroll_row", scroll_row, exp_scroll);
      check("lf_cursor", {cursor_row, cursor_col}, {2'd2, 2'd0});
   endtask

   initial begin
      int n;
      rst0 = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_attr = '0;
      rst1 = 1'b1; in_valid1 = 1'b0; in_char1 = 8'h00; in_attr1 = '0;
      fork
         monitor();
      join_none

      reset0();
      // Single printable byte
      push(0, 12'h541);
      send(8'h41, 4'h5);
      @(negedge clk);
      check("A_wr_en", wr_en, 1'b1);
      check("A_cursor_col", cursor_col, 2'd1);

      reset0();
      // "ABCD" wraps to row 1 without scrolling
      for (int i = 0; i < 4; i++) begin
         push(i, 12'h341 + 12'(i));
         send(8'h41 + 8'(i), 4'h3);
      end
      @(negedge clk);
      check("ABCD_cursor", {cursor_row, cursor_col}, {2'd1, 2'd0});
      check("ABCD_no_clear", {in_ready, busy}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         push(4 + i, 12'h345 + 12'(i));
         send(8'h45 + 8'(i), 4'h3);
      end
      wait_ready();
      check("EFGH_cursor", {cursor_row, cursor_col}, {2'd2, 2'd0});

      // LF on the last row scrolls and blanks physical row 0
      lf_scroll(0, 1);

      // 'X', BS, BS
      push(0, 12'h058);
      send(8'h58, 4'h0);
      push(0, 12'h020);
      send(8'h08, 4'h0);
      send(8'h08, 4'h0);
      @(negedge clk);
      check("BS_col0_no_write", wr_en, 1'b0);
      check("BS_cursor_col", cursor_col, 2'd0);

      // CR returns to column 0 without writing
      push(0, 12'h159);
      send(8'h59, 4'h1);
      push(1, 12'h25A);
      send(8'h5A, 4'h2);
      send(8'h0D, 4'h0);
      @(negedge clk);
      check("CR_no_write", wr_en, 1'b0);
      check("CR_cursor", {cursor_row, cursor_col}, {2'd2, 2'd0});

      // Unhandled control and high bytes are ignored
      send(8'h07, 4'h1);
      send(8'h80, 4'h1);
      @(negedge clk);
      check("ignored_no_write", wr_en, 1'b0);
      check("ignored_cursor", {cursor_row, cursor_col, scroll_row}, {2'd2, 2'd0, 2'd1});

      // Scroll through the wrap 2 -> 0 and back up to 2
      lf_scroll(4, 2);
      lf_scroll(8, 0);
      lf_scroll(0, 1);
      lf_scroll(4, 2);

      // Row 2 with scroll 2 lands on physical row 1
      push(4, 12'h751);
      send(8'h51, 4'h7);
      @(negedge clk);
      check("Q_cursor_col", cursor_col, 2'd1);

      // FF clears the whole screen and homes the cursor
      for (int i = 0; i < ROWS * COLS; i++) push(i, 12'h020);
      send(8'h0C, 4'h0);
      count_low(n);
      check("FF_ready_low_cycles", n, 13);
      check("FF_cursor_scroll", {cursor_row, cursor_col, scroll_row}, 6'd0);

      // LF above the last row only moves down
      send(8'h0A, 4'h0);
      @(negedge clk);
      check("LF_row_inc", {cursor_row, cursor_col}, {2'd1, 2'd0});
      check("LF_stays_idle", {in_ready, busy, wr_en}, 3'b100);
      check("scoreboard_drained", exp_q.size(), 0);

      // Clear-on-reset instance
      @(negedge clk);
      check("cor_rst_outputs", {wr_en1, in_ready1, busy1, wr_addr1, wr_data1}, 19'd0);
      @(posedge clk);
      #1 rst1 = 1'b0;
      @(negedge clk);
      check("cor_first_cycle_no_write", wr_en1, 1'b0);
      for (int i = 0; i < ROWS * COLS; i++) begin
         @(negedge clk);
         check("cor_wr_en", wr_en1, 1'b1);
         check("cor_wr_addr", wr_addr1, i);
         check("cor_wr_data", wr_data1, 12'h020);
         check("cor_busy_ready", {busy1, in_ready1}, 2'b10);
      end
      @(negedge clk);
      check("cor_done", {in_ready1, busy1, wr_en1}, 3'b100);

      // Reset during the 6th clear write aborts the clear
      @(posedge clk);
      #1 rst1 = 1'b1;
      @(posedge clk);
      #1 rst1 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_pre_addr", {wr_en1, wr_addr1}, {1'b1, 4'(i)});
      end
      rst1 = 1'b1;
      @(negedge clk);
      check("abort_wr_en", wr_en1, 1'b0);
      check("abort_ready_busy", {in_ready1, busy1}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
